// File: rtl/meriac_morse_pkg.sv
// Shared symbol encoding, FSM state type and element lengths for the morse keyer.
package meriac_morse_pkg;

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_GAP  = 2'b11;

  localparam logic [1:0] UNITS_DOT      = 2'd1;
  localparam logic [1:0] UNITS_DASH     = 2'd3;
  localparam logic [1:0] UNITS_GAP      = 2'd2;
  localparam logic [1:0] UNITS_ELEM_GAP = 2'd1;
  localparam logic [1:0] SETTLE_CYC     = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    MARK,
    SPACE,
    SETTLE,
    DONE
  } state_e;

  // The unit counter holds "remaining units after this one", so it is loaded with n-1.
  function automatic logic [1:0] units_load(input logic [1:0] units);
    return units - 2'd1;
  endfunction

endpackage

// File: rtl/meriac_morse_tone_gen.sv
// Square-wave tone divider; the phase restarts high on every rising edge of en.
module meriac_morse_tone_gen
  import meriac_morse_pkg::*;
#(
  parameter int TONE_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tone
);

  localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);

  logic [DW-1:0] div_q;
  logic          toggled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      toggled_q <= 1'b0;
    end else if (!en) begin
      div_q     <= '0;
      toggled_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q     <= '0;
      toggled_q <= ~toggled_q;
    end else begin
      div_q     <= div_q + DW'(1);
    end
  end

  // Stored as "has toggled" so the cleared state yields a high first mark cycle.
  assign tone = en & ~toggled_q;

endmodule

// File: rtl/meriac_morse_keyer.sv
// Morse keyer: turns database symbols into timed key/tone intervals and steps the symbol address.
module meriac_morse_keyer
  import meriac_morse_pkg::*;
#(
  parameter int UNIT_CNT = 5424,
  parameter int TONE_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym,
  input  logic       start,
  input  logic       loop,
  output logic       sym_advance,
  output logic       sym_rewind,
  output logic       key,
  output logic       tone,
  output logic       busy,
  output logic       done
);

  localparam int TW = (UNIT_CNT > 1) ? $clog2(UNIT_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_CNT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    unit_q, unit_d;
  logic          adv_q, adv_d;
  logic          rew_q, rew_d;
  logic          tick_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      unit_q  <= '0;
      adv_q   <= 1'b0;
      rew_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      adv_q   <= adv_d;
      rew_q   <= rew_d;
    end
  end

  assign tick_wrap = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    unit_d  = unit_q;
    adv_d   = 1'b0;
    rew_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = DECODE;
      end
      DECODE: begin
        case (sym)
          SYM_DOT: begin
            state_d = MARK;
            unit_d  = units_load(UNITS_DOT);
            adv_d   = 1'b1;
          end
          SYM_DASH: begin
            state_d = MARK;
            unit_d  = units_load(UNITS_DASH);
            adv_d   = 1'b1;
          end
          SYM_GAP: begin
            state_d = SPACE;
            unit_d  = units_load(UNITS_GAP);
            adv_d   = 1'b1;
          end
          default: begin
            if (loop) begin
              state_d = SETTLE;
              unit_d  = units_load(SETTLE_CYC);
              rew_d   = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        endcase
      end
      MARK, SPACE: begin
        if (!tick_wrap) begin
          tick_d = tick_q + TW'(1);
        end else if (unit_q != 2'd0) begin
          unit_d = unit_q - 2'd1;
        end else if (state_q == MARK) begin
          // Every mark is followed by its own inter-element gap.
          state_d = SPACE;
          unit_d  = units_load(UNITS_ELEM_GAP);
        end else begin
          state_d = DECODE;
        end
      end
      SETTLE: begin
        // One cycle for the rewind pulse, one for the upstream address to land.
        if (unit_q == 2'd0) state_d = DECODE;
        else                unit_d  = unit_q - 2'd1;
      end
      DONE: begin
        if (start) begin
          state_d = SETTLE;
          unit_d  = units_load(SETTLE_CYC);
          rew_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key         = (state_q == MARK);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign sym_advance = adv_q;
  assign sym_rewind  = rew_q;

  meriac_morse_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (key),
    .tone  (tone)
  );

endmodule

// File: tb/tb_meriac_morse_keyer.sv
// Bench for meriac_morse_keyer: symbol database model plus a per-cycle message-level reference.
module tb_meriac_morse_keyer;

  localparam int UNIT_CNT = 4;
  localparam int TONE_DIV = 2;
  localparam logic [1:0] S_END = 2'b00, S_DOT = 2'b01, S_DASH = 2'b10, S_GAP = 2'b11;

  typedef struct packed {
    logic key;
    logic tone;
    logic busy;
    logic done;
    logic adv;
    logic rew;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       loop = 1'b0;
  logic [1:0] sym;
  logic       sym_advance, sym_rewind, key, tone, busy, done;

  meriac_morse_keyer #(
    .UNIT_CNT (UNIT_CNT),
    .TONE_DIV (TONE_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sym         (sym),
    .start       (start),
    .loop        (loop),
    .sym_advance (sym_advance),
    .sym_rewind  (sym_rewind),
    .key         (key),
    .tone        (tone),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Upstream symbol database: address steps on the keyer's pulses.
  logic [1:0] mem [0:15];
  logic [3:0] addr;
  always @(posedge clk or posedge reset) begin
    if (reset)            addr <= 4'd0;
    else if (sym_rewind)  addr <= 4'd0;
    else if (sym_advance) addr <= addr + 4'd1;
  end
  assign sym = mem[addr];

  int n_chk  = 0;
  int n_fail = 0;
  int key_hi_cnt, adv_cnt, rew_cnt;
  logic [1:0] msg[$];
  obs_t expq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    return '{key: key, tone: tone, busy: busy, done: done, adv: sym_advance, rew: sym_rewind};
  endfunction

  function automatic obs_t mk(input logic k, input logic t, input logic b, input logic d,
                              input logic a, input logic r);
    return '{key: k, tone: t, busy: b, done: d, adv: a, rew: r};
  endfunction

  // Expected per-cycle outputs, cycle 0 being the first DECODE cycle after start is taken.
  task automatic build_model(input bit lp, input int ncyc, input bit settle_first);
    int i = 0;
    expq.delete();
    if (settle_first) begin
      expq.push_back(mk(0, 0, 1, 0, 0, 1));
      expq.push_back(mk(0, 0, 1, 0, 0, 0));
    end
    while (expq.size() < ncyc) begin
      logic [1:0] s;
      s = msg[i];
      expq.push_back(mk(0, 0, 1, 0, 0, 0));
      if (s == S_DOT || s == S_DASH) begin
        int units;
        units = (s == S_DOT) ? 1 : 3;
        for (int k = 0; k < units * UNIT_CNT; k++)
          expq.push_back(mk(1, ((k / TONE_DIV) % 2) == 0, 1, 0, k == 0, 0));
        for (int k = 0; k < UNIT_CNT; k++)
          expq.push_back(mk(0, 0, 1, 0, 0, 0));
        i++;
      end else if (s == S_GAP) begin
        for (int k = 0; k < 2 * UNIT_CNT; k++)
          expq.push_back(mk(0, 0, 1, 0, k == 0, 0));
        i++;
      end else if (lp) begin
        expq.push_back(mk(0, 0, 1, 0, 0, 1));
        expq.push_back(mk(0, 0, 1, 0, 0, 0));
        i = 0;
      end else begin
        while (expq.size() < ncyc) expq.push_back(mk(0, 0, 0, 1, 0, 0));
      end
    end
    while (expq.size() > ncyc) void'(expq.pop_back());
  endtask

  task automatic load_mem();
    for (int j = 0; j < 16; j++) mem[j] = (j < msg.size()) ? msg[j] : S_END;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_eq({name, ":reset"}, 32'(sample()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Walks expq cycle by cycle; start noise only lands on cycles where the keyer is busy.
  task automatic check_trace(input string name, input bit noise);
    for (int c = 0; c < expq.size(); c++) begin
      obs_t o;
      o = sample();
      check_eq($sformatf("%s:cyc%0d", name, c), 32'(o), 32'(expq[c]));
      key_hi_cnt += int'(o.key);
      adv_cnt    += int'(o.adv);
      rew_cnt    += int'(o.rew);
      start = (noise && expq[c].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run_case(input string name, input bit lp, input int ncyc,
                          input bit noise, input bit restart);
    load_mem();
    loop = lp;
    key_hi_cnt = 0;
    adv_cnt = 0;
    rew_cnt = 0;
    do_reset(name);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    build_model(lp, ncyc, 1'b0);
    check_trace(name, noise);
    if (restart) begin
      check_eq({name, ":in_done"}, 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      build_model(lp, ncyc, 1'b1);
      check_trace({name, ":replay"}, noise);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg = '{S_DOT, S_END};
    run_case("dot", 1'b0, 16, 1'b0, 1'b0);
    check_eq("dot:key_cycles", 32'(key_hi_cnt), 32'd4);
    check_eq("dot:adv_pulses", 32'(adv_cnt), 32'd1);

    msg = '{S_DASH, S_END};
    run_case("dash", 1'b0, 24, 1'b0, 1'b0);
    check_eq("dash:key_cycles", 32'(key_hi_cnt), 32'd12);

    msg = '{S_DOT, S_GAP, S_GAP, S_GAP, S_DOT, S_END};
    run_case("gaps", 1'b0, 50, 1'b0, 1'b0);
    check_eq("gaps:adv_pulses", 32'(adv_cnt), 32'd5);

    msg = '{S_DOT, S_END};
    run_case("loop", 1'b1, 40, 1'b0, 1'b0);
    check_eq("loop:rew_pulses", 32'(rew_cnt), 32'd3);

    msg = '{S_DASH, S_DOT, S_END};
    run_case("restart", 1'b0, 30, 1'b0, 1'b1);

    msg = '{S_DOT, S_GAP, S_DASH, S_GAP, S_GAP, S_DOT, S_END};
    run_case("busy_start", 1'b0, 70, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a dash.
    msg = '{S_DASH, S_END};
    load_mem();
    loop = 1'b0;
    do_reset("arst");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("arst:key_before", 32'(key), 32'd1);
    check_eq("arst:tone_before", 32'(tone), 32'd1);
    reset = 1'b1;
    #2;
    check_eq("arst:outputs_now", 32'(sample()), 32'd0);
    check_eq("arst:addr_now", 32'(addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("arst:idle%0d", c), 32'(sample()), 32'd0);
      @(posedge clk);
      #1;
    end

    for (int r = 0; r < 6; r++) begin
      int n;
      bit lp;
      n = $urandom_range(1, 6);
      msg.delete();
      for (int j = 0; j < n; j++) msg.push_back(2'($urandom_range(1, 3)));
      msg.push_back(S_END);
      lp = 1'($urandom_range(0, 1));
      run_case($sformatf("rand%0d", r), lp, 120, 1'b1, !lp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
